// File: rtl/ff_ram_wb_pkg.sv
// Shared types and constants for the two-master Wishbone front-end of the byte-wide ff_ram.
package ff_ram_wb_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        ACK
    } state_t;

endpackage

// File: rtl/ff_ram_rr_arb.sv
// Two-way round-robin arbiter; purely combinational, one-hot grant, idle when en is low.
module ff_ram_rr_arb
    import ff_ram_wb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    // On a tie, the master that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (last_grant == GNT_M1) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/ff_ram_wb_arb.sv
// Arbitrates two 32-bit Wishbone-style masters onto one byte-wide ff_ram, splitting
// each word access into four byte accesses and assembling read data into rdt.
module ff_ram_wb_arb
    import ff_ram_wb_pkg::*;
#(
    parameter int unsigned aw = 10
) (
    input  logic          clk0,
    input  logic          reset,
    input  logic [aw-1:0] m0_adr,
    input  logic [31:0]   m0_dat,
    input  logic [3:0]    m0_sel,
    input  logic          m0_we,
    input  logic          m0_cyc,
    output logic          m0_ack,
    input  logic [aw-1:0] m1_adr,
    input  logic [31:0]   m1_dat,
    input  logic [3:0]    m1_sel,
    input  logic          m1_we,
    input  logic          m1_cyc,
    output logic          m1_ack,
    output logic [31:0]   rdt,
    output logic          ram_csb0,
    output logic [aw-1:0] ram_addr0,
    output logic [7:0]    ram_din0,
    output logic          ram_csb1,
    output logic [aw-1:0] ram_addr1,
    input  logic [7:0]    ram_dout1
);

    localparam int unsigned WA_W = aw - LANE_W;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WA_W-1:0]     wadr_q, wadr_d;
    logic [WORD_W-1:0]   dat_q, dat_d;
    logic [WORD_W-1:0]   rdt_q, rdt_d;
    logic [LANES-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic                last_grant_q, last_grant_d;
    logic                m0_ack_q, m0_ack_d;
    logic                m1_ack_q, m1_ack_d;
    logic [1:0]          gnt;
    logic [LANE_W-1:0]   cap_lane;
    logic                unused_adr_lsbs;

    // Byte-within-word bits of the master addresses are replaced by the lane counter.
    assign unused_adr_lsbs = ^{m0_adr[LANE_W-1:0], m1_adr[LANE_W-1:0]};

    ff_ram_rr_arb u_arb (
        .req        ({m1_cyc, m0_cyc}),
        .last_grant (last_grant_q),
        .en         (state_q == IDLE),
        .gnt        (gnt)
    );

    // RAM data lags the address by one cycle; in DRAIN the lane has wrapped to 0, so this is lane 3.
    assign cap_lane = lane_q - LANE_W'(1);

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        wadr_d       = wadr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        rdt_d        = rdt_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    last_grant_d = gnt[1] ? GNT_M1 : GNT_M0;
                    wadr_d       = gnt[1] ? m1_adr[aw-1:LANE_W] : m0_adr[aw-1:LANE_W];
                    dat_d        = gnt[1] ? m1_dat : m0_dat;
                    sel_d        = gnt[1] ? m1_sel : m0_sel;
                    we_d         = gnt[1] ? m1_we  : m0_we;
                    lane_d       = '0;
                    state_d      = (gnt[1] ? m1_we : m0_we) ? WRITE : READ;
                end
            end
            WRITE: begin
                lane_d = lane_q + LANE_W'(1);
                if (lane_q == LAST_LANE) begin
                    state_d = ACK;
                end
            end
            READ: begin
                lane_d = lane_q + LANE_W'(1);
                if (lane_q != '0) begin
                    rdt_d[{cap_lane, 3'b000} +: BYTE_W] = ram_dout1;
                end
                if (lane_q == LAST_LANE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                rdt_d[{cap_lane, 3'b000} +: BYTE_W] = ram_dout1;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        m0_ack_d = (state_d == ACK) && (last_grant_q == GNT_M0);
        m1_ack_d = (state_d == ACK) && (last_grant_q == GNT_M1);
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            wadr_q       <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            last_grant_q <= GNT_M1;
            rdt_q        <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            wadr_q       <= wadr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            rdt_q        <= rdt_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
        end
    end

    // RAM strobes depend only on registered state so master inputs cannot glitch them.
    assign ram_addr0 = {wadr_q, lane_q};
    assign ram_din0  = dat_q[{lane_q, 3'b000} +: BYTE_W];
    assign ram_csb0  = !((state_q == WRITE) && sel_q[lane_q]);
    assign ram_addr1 = {wadr_q, lane_q};
    assign ram_csb1  = (state_q != READ);

    assign m0_ack = m0_ack_q;
    assign m1_ack = m1_ack_q;
    assign rdt    = rdt_q;

endmodule
